vpu_req_decoder: RTL and testbench

//  VPU-side receiver for 136-bit host-to-device instructions (vpu_h2d_req_instr_t). It buffers

---
 rtl/vpu_req_decoder.sv | 246 ++++++++++++++++++++++++
 tb/tb_vpu_req_decoder.sv | 418 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vpu_req_decoder.sv
// ============================================================================
//  Module      : vpu_req_decoder
//  Description : VPU-side receiver for 136-bit host-to-device instructions.
//                Buffers instructions in a FIFO, validates the opcode, splits
//                src0..src2/dst0 into SRAM bank id and row address, issues
//                bank-conflict-free read groups to the SRAM read ports, then
//                presents an execute descriptor to the vector lanes.
//
//  Ports       : clk, rst_n              clock, async active-low reset
//                instr_valid/ready/instr host instruction port
//                                        {opcode[135:128],src2,src1,src0,dst0}
//                rd_valid/bank/row/ready SRAM read group (whole group per beat)
//                ex_valid/ready/opcode/src_cnt/dst_bank/dst_row
//                                        execute descriptor to VLANE
//                err_opcode              1-cycle pulse on invalid-opcode drop
//                fifo_cnt                buffer occupancy 0..FIFO_DEPTH
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module vpu_req_decoder #(
    parameter int FIFO_DEPTH = 16,  // power of 2, >= 2
    parameter int RD_PORTS   = 3,   // one read port per source operand (<= 3)
    parameter int BANK_W     = 2,
    parameter int ROW_W      = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [135:0]                  instr,
    output logic [RD_PORTS-1:0]           rd_valid,
    output logic [RD_PORTS*BANK_W-1:0]    rd_bank,
    output logic [RD_PORTS*ROW_W-1:0]     rd_row,
    input  logic                          rd_ready,
    output logic                          ex_valid,
    input  logic                          ex_ready,
    output logic [7:0]                    ex_opcode,
    output logic [1:0]                    ex_src_cnt,
    output logic [BANK_W-1:0]             ex_dst_bank,
    output logic [ROW_W-1:0]              ex_dst_row,
    output logic                          err_opcode,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_cnt
);

    localparam int PTR_W    = $clog2(FIFO_DEPTH);
    localparam int CNT_W    = PTR_W + 1;
    localparam int ADR_W    = BANK_W + ROW_W;   // {row, bank} slice of an address
    localparam int ADDR_LSB = 9;                // bank starts at address bit 9
    localparam int NOPS     = RD_PORTS + 1;     // operand 0 is dst0, 1.. are sources
    localparam int ENT_W    = 8 + NOPS * ADR_W;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_EX   = 2'd2
    } state_t;

    // Only the opcode and the bank/row slice of each operand are buffered.
    logic [ENT_W-1:0] w_wr_ent;
    logic             w_unused;

    assign w_wr_ent[ENT_W-1 -: 8] = instr[135:128];
    generate
        for (genvar k = 0; k < NOPS; k++) begin : g_pack
            assign w_wr_ent[k*ADR_W +: ADR_W] = instr[32*k + ADDR_LSB +: ADR_W];
        end
    endgenerate
    assign w_unused = ^instr;

    // ------------------------------------------------------------------
    // Instruction FIFO
    // ------------------------------------------------------------------
    logic [ENT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wptr;
    logic [PTR_W-1:0] r_rptr;
    logic [CNT_W-1:0] r_cnt;
    logic             w_full;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [ENT_W-1:0] w_head;

    assign w_full      = (r_cnt == CNT_W'(FIFO_DEPTH));
    assign w_empty     = (r_cnt == '0);
    // A full FIFO refuses pushes even when a pop happens in the same cycle.
    assign w_push      = instr_valid && !w_full;
    assign instr_ready = !w_full;
    assign fifo_cnt    = r_cnt;
    assign w_head      = r_mem[r_rptr];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= w_wr_ent;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
        end else begin
            if (w_push) r_wptr <= r_wptr + 1'b1;
            if (w_pop)  r_rptr <= r_rptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Head decode
    // ------------------------------------------------------------------
    function automatic logic [1:0] f_src_cnt(input logic [7:0] op);
        case (op)
            8'h05, 8'h0C, 8'h0D:                      f_src_cnt = 2'd1;
            8'h0B:                                    f_src_cnt = 2'd3;
            8'h01, 8'h02, 8'h03, 8'h04, 8'h06, 8'h07,
            8'h08, 8'h09, 8'h0A, 8'h0E:               f_src_cnt = 2'd2;
            default:                                  f_src_cnt = 2'd0; // invalid
        endcase
    endfunction

    logic [7:0]          w_op;
    logic [1:0]          w_src_cnt;
    logic [BANK_W-1:0]   w_src_bank [RD_PORTS];
    logic [ROW_W-1:0]    w_src_row  [RD_PORTS];
    logic [RD_PORTS-1:0] w_init_mask;

    assign w_op      = w_head[ENT_W-1 -: 8];
    assign w_src_cnt = f_src_cnt(w_op);

    generate
        for (genvar i = 0; i < RD_PORTS; i++) begin : g_src
            assign w_src_bank[i] = w_head[(i+1)*ADR_W +: BANK_W];
            assign w_src_row[i]  = w_head[(i+1)*ADR_W + BANK_W +: ROW_W];
        end
    endgenerate

    always_comb begin
        w_init_mask = '0;
        for (int i = 0; i < RD_PORTS; i++) begin
            w_init_mask[i] = (int'(w_src_cnt) > i);
        end
    end

    // ------------------------------------------------------------------
    // Read-group selection: a pending operand joins the group only if its
    // bank differs from every lower-indexed operand already in the group.
    // ------------------------------------------------------------------
    state_t              r_state;
    state_t              w_state_nxt;
    logic [RD_PORTS-1:0] r_pend;
    logic [RD_PORTS-1:0] w_pend_nxt;
    logic [RD_PORTS-1:0] w_group;
    logic                w_hit;

    always_comb begin
        w_group = '0;
        w_hit   = 1'b0;
        for (int i = 0; i < RD_PORTS; i++) begin
            w_hit = 1'b0;
            for (int j = 0; j < i; j++) begin
                if (w_group[j] && (w_src_bank[j] == w_src_bank[i])) begin
                    w_hit = 1'b1;
                end
            end
            w_group[i] = r_pend[i] && !w_hit;
        end
    end

    // ------------------------------------------------------------------
    // Control FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_pend  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_pend  <= w_pend_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pend_nxt  = r_pend;
        w_pop       = 1'b0;
        err_opcode  = 1'b0;
        rd_valid    = '0;
        ex_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!w_empty) begin
                    if (w_src_cnt == 2'd0) begin
                        err_opcode = 1'b1;
                        w_pop      = 1'b1;
                    end else begin
                        w_pend_nxt  = w_init_mask;
                        w_state_nxt = S_RD;
                    end
                end
            end
            S_RD: begin
                rd_valid = w_group;
                if (rd_ready) begin
                    w_pend_nxt = r_pend & ~w_group;
                    if ((r_pend & ~w_group) == '0) begin
                        w_state_nxt = S_EX;
                    end
                end
            end
            S_EX: begin
                ex_valid = 1'b1;
                if (ex_ready) begin
                    w_pop       = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Data outputs are forced to zero outside their valid window so stale
    // FIFO contents never appear on the interfaces.
    generate
        for (genvar i = 0; i < RD_PORTS; i++) begin : g_rdout
            assign rd_bank[i*BANK_W +: BANK_W] = rd_valid[i] ? w_src_bank[i] : '0;
            assign rd_row[i*ROW_W +: ROW_W]    = rd_valid[i] ? w_src_row[i]  : '0;
        end
    endgenerate

    assign ex_opcode   = ex_valid ? w_op : 8'd0;
    assign ex_src_cnt  = ex_valid ? w_src_cnt : 2'd0;
    assign ex_dst_bank = ex_valid ? w_head[0 +: BANK_W] : '0;
    assign ex_dst_row  = ex_valid ? w_head[BANK_W +: ROW_W] : '0;

endmodule

`default_nettype wire

// File: tb/tb_vpu_req_decoder.sv
// ============================================================================
//  Module      : tb_vpu_req_decoder
//  Description : Self-checking bench for vpu_req_decoder. A reference model
//                queues expected read groups, execute descriptors and opcode
//                errors when an instruction is accepted; a monitor pops and
//                compares them as the DUT hands them over. Scenario tasks add
//                their own timing/stability checks.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_vpu_req_decoder;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          instr_valid = 1'b0;
    logic          instr_ready;
    logic [135:0]  instr = '0;
    logic [2:0]    rd_valid;
    logic [5:0]    rd_bank;
    logic [29:0]   rd_row;
    logic          rd_ready = 1'b0;
    logic          ex_valid;
    logic          ex_ready = 1'b0;
    logic [7:0]    ex_opcode;
    logic [1:0]    ex_src_cnt;
    logic [1:0]    ex_dst_bank;
    logic [9:0]    ex_dst_row;
    logic          err_opcode;
    logic [4:0]    fifo_cnt;

    vpu_req_decoder #(
        .FIFO_DEPTH (16),
        .RD_PORTS   (3),
        .BANK_W     (2),
        .ROW_W      (10)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .rd_valid    (rd_valid),
        .rd_bank     (rd_bank),
        .rd_row      (rd_row),
        .rd_ready    (rd_ready),
        .ex_valid    (ex_valid),
        .ex_ready    (ex_ready),
        .ex_opcode   (ex_opcode),
        .ex_src_cnt  (ex_src_cnt),
        .ex_dst_bank (ex_dst_bank),
        .ex_dst_row  (ex_dst_row),
        .err_opcode  (err_opcode),
        .fifo_cnt    (fifo_cnt)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct packed {
        logic [2:0]  v;
        logic [5:0]  b;
        logic [29:0] r;
    } rd_t;

    typedef struct packed {
        logic [7:0] op;
        logic [1:0] cnt;
        logic [1:0] db;
        logic [9:0] dr;
    } ex_t;

    rd_t        exp_rd[$];
    ex_t        exp_ex[$];
    logic [7:0] exp_err[$];

    function automatic logic [135:0] mk(input logic [7:0] op, input logic [31:0] s2,
                                        input logic [31:0] s1, input logic [31:0] s0,
                                        input logic [31:0] d);
        return {op, s2, s1, s0, d};
    endfunction

    function automatic int model_cnt(input logic [7:0] op);
        if (op == 8'h05 || op == 8'h0C || op == 8'h0D) return 1;
        if (op == 8'h0B) return 3;
        if ((op >= 8'h01 && op <= 8'h04) || (op >= 8'h06 && op <= 8'h0A) || op == 8'h0E) return 2;
        return 0;
    endfunction

    // Reference model: expected traffic for one accepted instruction.
    task automatic sb_push(input logic [135:0] ins);
        logic [7:0] op;
        int         cnt;
        logic [2:0] pend;
        logic [1:0] bk [3];
        logic [9:0] rw [3];
        rd_t        g;
        logic       clash;
        ex_t        e;
        op  = ins[135:128];
        cnt = model_cnt(op);
        if (cnt == 0) begin
            exp_err.push_back(op);
        end else begin
            pend = 3'((1 << cnt) - 1);
            for (int i = 0; i < 3; i++) begin
                bk[i] = ins[32*(i+1) + 9 +: 2];
                rw[i] = ins[32*(i+1) + 11 +: 10];
            end
            while (pend != 3'b000) begin
                g = '0;
                for (int i = 0; i < 3; i++) begin
                    if (pend[i]) begin
                        clash = 1'b0;
                        for (int j = 0; j < i; j++)
                            if (g.v[j] && bk[j] == bk[i]) clash = 1'b1;
                        if (!clash) begin
                            g.v[i]          = 1'b1;
                            g.b[2*i +: 2]   = bk[i];
                            g.r[10*i +: 10] = rw[i];
                        end
                    end
                end
                pend = pend & ~g.v;
                exp_rd.push_back(g);
            end
            e.op  = op;
            e.cnt = 2'(cnt);
            e.db  = ins[10:9];
            e.dr  = ins[20:11];
            exp_ex.push_back(e);
        end
    endtask

    // Monitor: compares DUT hand-offs against the model queues.
    rd_t m_rd;
    ex_t m_ex;
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_valid != 3'b000 && ex_valid) begin
                n_total++;
                $display("FAIL rd_ex_overlap rd_valid=%b ex_valid=%b required exclusive", rd_valid, ex_valid);
            end
            if (rd_valid != 3'b000 && rd_ready) begin
                n_total++;
                if (exp_rd.size() == 0) begin
                    $display("FAIL rd_group got v=%b unexpected (none queued)", rd_valid);
                end else begin
                    m_rd = exp_rd.pop_front();
                    if ({rd_valid, rd_bank, rd_row} !== m_rd)
                        $display("FAIL rd_group got v=%b b=%h r=%h required v=%b b=%h r=%h",
                                 rd_valid, rd_bank, rd_row, m_rd.v, m_rd.b, m_rd.r);
                    else n_pass++;
                end
            end
            if (ex_valid && ex_ready) begin
                n_total++;
                if (exp_ex.size() == 0) begin
                    $display("FAIL ex_desc got op=%h unexpected (none queued)", ex_opcode);
                end else begin
                    m_ex = exp_ex.pop_front();
                    if ({ex_opcode, ex_src_cnt, ex_dst_bank, ex_dst_row} !== m_ex)
                        $display("FAIL ex_desc got op=%h cnt=%0d db=%0d dr=%0d required op=%h cnt=%0d db=%0d dr=%0d",
                                 ex_opcode, ex_src_cnt, ex_dst_bank, ex_dst_row,
                                 m_ex.op, m_ex.cnt, m_ex.db, m_ex.dr);
                    else n_pass++;
                end
            end
            if (err_opcode) begin
                n_total++;
                if (exp_err.size() == 0) begin
                    $display("FAIL err_opcode got 1 required 0 (no invalid opcode queued)");
                end else begin
                    void'(exp_err.pop_front());
                    n_pass++;
                end
            end
        end
    end

    // Drives one instruction and leaves instr_valid high for back-to-back use.
    task automatic push(input logic [135:0] ins);
        int b;
        instr       = ins;
        instr_valid = 1'b1;
        b = 0;
        while (!instr_ready && b < 100) begin
            @(posedge clk); #1;
            b++;
        end
        if (!instr_ready) begin
            n_total++;
            $display("FAIL push_timeout instr_ready=%b fifo_cnt=%0d required accept", instr_ready, fifo_cnt);
        end else begin
            sb_push(ins);
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_idle();
        int b;
        b = 0;
        while ((exp_rd.size() != 0 || exp_ex.size() != 0 || exp_err.size() != 0 ||
                fifo_cnt != 0 || ex_valid || rd_valid != 3'b000) && b < 400) begin
            @(posedge clk); #1;
            b++;
        end
        n_total++;
        if (b >= 400)
            $display("FAIL drain fifo_cnt=%0d rd_q=%0d ex_q=%0d required all empty",
                     fifo_cnt, exp_rd.size(), exp_ex.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_total++;
        if ({instr_ready, rd_valid, ex_valid, err_opcode, fifo_cnt} !== {1'b1, 3'b0, 1'b0, 1'b0, 5'd0})
            $display("FAIL reset_ctrl got rdy=%b rv=%b ev=%b err=%b cnt=%0d required 1,0,0,0,0",
                     instr_ready, rd_valid, ex_valid, err_opcode, fifo_cnt);
        else n_pass++;
        n_total++;
        if ({rd_bank, rd_row, ex_opcode, ex_src_cnt, ex_dst_bank, ex_dst_row} !== '0)
            $display("FAIL reset_data got b=%h r=%h op=%h required 0", rd_bank, rd_row, ex_opcode);
        else n_pass++;
        rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_fadd();
        rd_ready = 1'b1;
        ex_ready = 1'b1;
        push(mk(8'h07, 32'h0, 32'h200, 32'h0, 32'h800));
        instr_valid = 1'b0;
        n_total++;
        if (rd_valid !== 3'b000 || fifo_cnt !== 5'd1)
            $display("FAIL fadd_idle_cycle got rv=%b cnt=%0d required 000,1", rd_valid, fifo_cnt);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (rd_valid !== 3'b011 || rd_bank !== 6'b000100 || rd_row !== 30'd0)
            $display("FAIL fadd_group got rv=%b b=%b r=%h required 011,000100,0", rd_valid, rd_bank, rd_row);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (ex_valid !== 1'b1 || rd_valid !== 3'b000)
            $display("FAIL fadd_ex got ev=%b rv=%b required 1,000", ex_valid, rd_valid);
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_favg();
        rd_ready = 1'b1;
        ex_ready = 1'b1;
        push(mk(8'h0B, 32'h1400, 32'h0C00, 32'h0400, 32'h2A00));
        instr_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_bad_opcode();
        rd_ready = 1'b1;
        ex_ready = 1'b1;
        push(mk(8'h3F, 32'h0, 32'h0, 32'h0, 32'h0));
        instr_valid = 1'b0;
        n_total++;
        if (err_opcode !== 1'b1 || rd_valid !== 3'b000 || ex_valid !== 1'b0)
            $display("FAIL bad_op_pulse got err=%b rv=%b ev=%b required 1,000,0", err_opcode, rd_valid, ex_valid);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (err_opcode !== 1'b0 || fifo_cnt !== 5'd0 || rd_valid !== 3'b000 || ex_valid !== 1'b0)
            $display("FAIL bad_op_after got err=%b cnt=%0d rv=%b ev=%b required 0,0,000,0",
                     err_opcode, fifo_cnt, rd_valid, ex_valid);
        else n_pass++;
        wait_idle();
    endtask

    task automatic test_full_stall();
        logic [5:0]  hb;
        logic [29:0] hr;
        rd_ready = 1'b0;
        ex_ready = 1'b1;
        for (int i = 0; i < 16; i++)
            push(mk(8'h05, 32'h0, 32'h0, 32'((i << 11) | ((i & 3) << 9)), 32'h0));
        instr = mk(8'h05, 32'h0, 32'h0, 32'((16 << 11) | (1 << 9)), 32'h0);
        @(negedge clk);
        n_total++;
        if (fifo_cnt !== 5'd16 || instr_ready !== 1'b0 || rd_valid !== 3'b001)
            $display("FAIL full_state got cnt=%0d rdy=%b rv=%b required 16,0,001", fifo_cnt, instr_ready, rd_valid);
        else n_pass++;
        hb = rd_bank;
        hr = rd_row;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            n_total++;
            if (fifo_cnt !== 5'd16 || instr_ready !== 1'b0 || rd_valid !== 3'b001 ||
                rd_bank !== hb || rd_row !== hr || rd_bank !== 6'd0 || rd_row !== 30'd0)
                $display("FAIL stall_hold got cnt=%0d rdy=%b rv=%b b=%h r=%h required 16,0,001,0,0",
                         fifo_cnt, instr_ready, rd_valid, rd_bank, rd_row);
            else n_pass++;
        end
        @(posedge clk); #1;
        rd_ready = 1'b1;
        push(instr);
        instr_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [7:0] hop;
        logic [9:0] hdr;
        int b;
        rd_ready = 1'b1;
        ex_ready = 1'b0;
        push(mk(8'h0C, 32'h0, 32'h0, 32'h1200, 32'h1E00));
        push(mk(8'h08, 32'h0, 32'h2E00, 32'h0600, 32'h0A00));
        instr_valid = 1'b0;
        b = 0;
        while (!ex_valid && b < 20) begin
            @(posedge clk); #1;
            b++;
        end
        n_total++;
        if (ex_valid !== 1'b1 || ex_opcode !== 8'h0C || ex_src_cnt !== 2'd1 ||
            ex_dst_bank !== 2'd3 || ex_dst_row !== 10'd3)
            $display("FAIL b2b_first got ev=%b op=%h cnt=%0d db=%0d dr=%0d required 1,0c,1,3,3",
                     ex_valid, ex_opcode, ex_src_cnt, ex_dst_bank, ex_dst_row);
        else n_pass++;
        hop = ex_opcode;
        hdr = ex_dst_row;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_total++;
            if (ex_valid !== 1'b1 || ex_opcode !== hop || ex_dst_row !== hdr ||
                rd_valid !== 3'b000 || fifo_cnt !== 5'd2)
                $display("FAIL b2b_hold got ev=%b op=%h dr=%0d rv=%b cnt=%0d required 1,%h,%0d,000,2",
                         ex_valid, ex_opcode, ex_dst_row, rd_valid, fifo_cnt, hop, hdr);
            else n_pass++;
        end
        @(posedge clk); #1;
        ex_ready = 1'b1;
        wait_idle();
    endtask

    task automatic test_random();
        logic [7:0] ops [10];
        logic [7:0] op;
        rd_ready = 1'b1;
        ex_ready = 1'b1;
        ops = '{8'h01, 8'h02, 8'h05, 8'h0B, 8'h0B, 8'h0C, 8'h0E, 8'h0A, 8'h0D, 8'h3F};
        for (int i = 0; i < 12; i++) begin
            op = ops[$urandom_range(0, 9)];
            push(mk(op, $urandom, $urandom, $urandom, $urandom));
        end
        instr_valid = 1'b0;
        wait_idle();
    endtask

    task automatic test_reset_mid_rd();
        int b;
        rd_ready = 1'b0;
        ex_ready = 1'b1;
        push(mk(8'h0B, 32'h1400, 32'h0C00, 32'h0400, 32'h0));
        instr_valid = 1'b0;
        b = 0;
        while (rd_valid == 3'b000 && b < 20) begin
            @(posedge clk); #1;
            b++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({rd_valid, ex_valid, err_opcode, fifo_cnt, rd_bank, rd_row, ex_opcode} !== '0 || instr_ready !== 1'b1)
            $display("FAIL async_reset got rv=%b ev=%b cnt=%0d b=%h r=%h rdy=%b required all 0, rdy 1",
                     rd_valid, ex_valid, fifo_cnt, rd_bank, rd_row, instr_ready);
        else n_pass++;
        exp_rd.delete();
        exp_ex.delete();
        exp_err.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rd_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            n_total++;
            if (rd_valid !== 3'b000 || ex_valid !== 1'b0 || fifo_cnt !== 5'd0)
                $display("FAIL post_reset_idle got rv=%b ev=%b cnt=%0d required 000,0,0", rd_valid, ex_valid, fifo_cnt);
            else n_pass++;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fadd();
        test_favg();
        test_bad_opcode();
        test_full_stall();
        test_back_to_back();
        test_random();
        test_reset_mid_rd();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

`default_nettype wire
